// File: rtl/pipe_stage_skid_pkg.sv
// Shared constants for the elastic pipeline stage: control-bundle bit positions,
// state encoding and default payload widths.
package pipe_stage_skid_pkg;

  localparam int unsigned DEF_DATA_W      = 32;
  localparam int unsigned DEF_PC_W        = 32;
  localparam int unsigned DEF_CTRL_W      = 12;
  localparam int unsigned DEF_STALL_CNT_W = 16;

  localparam int unsigned CTRL_REGDST     = 11;
  localparam int unsigned CTRL_REGWRITE   = 10;
  localparam int unsigned CTRL_ALUSRC     = 9;
  localparam int unsigned CTRL_MEMREAD    = 8;
  localparam int unsigned CTRL_MEMWRITE   = 7;
  localparam int unsigned CTRL_MEMTOREG   = 6;
  localparam int unsigned CTRL_JTOPC      = 5;
  localparam int unsigned CTRL_BRANCH     = 4;
  localparam int unsigned CTRL_ALUOP_MSB  = 3;
  localparam int unsigned CTRL_ALUOP_LSB  = 0;

  // EMPTY: no entries, FULL: main only, SKID: main and skid
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StFull  = 2'd1,
    StSkid  = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Upstream/downstream handshake bundle of one pipeline stage, plus flush and stall telemetry.
interface pipe_stage_skid_if #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned PC_W        = 32,
  parameter int unsigned CTRL_W      = 12,
  parameter int unsigned STALL_CNT_W = 16
);

  logic                   in_valid;
  logic                   in_ready;
  logic [DATA_W-1:0]      in_data;
  logic [PC_W-1:0]        in_pc;
  logic [CTRL_W-1:0]      in_ctrl;
  logic                   out_valid;
  logic                   out_ready;
  logic [DATA_W-1:0]      out_data;
  logic [PC_W-1:0]        out_pc;
  logic [CTRL_W-1:0]      out_ctrl;
  logic                   flush;
  logic [STALL_CNT_W-1:0] stall_cnt;

  // master drives the stage (upstream producer + downstream consumer)
  modport master (
    output in_valid, in_data, in_pc, in_ctrl, out_ready, flush,
    input  in_ready, out_valid, out_data, out_pc, out_ctrl, stall_cnt
  );

  modport slave (
    input  in_valid, in_data, in_pc, in_ctrl, out_ready, flush,
    output in_ready, out_valid, out_data, out_pc, out_ctrl, stall_cnt
  );

endinterface

// File: rtl/pipe_entry_reg.sv
// Load-enable register holding one packed {data, pc, ctrl} pipeline entry.
module pipe_entry_reg #(
  parameter int unsigned WIDTH = 76
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             load_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] entry_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      entry_q <= '0;
    end else if (load_i) begin
      entry_q <= d_i;
    end
  end

  assign q_o = entry_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline register with a one-entry skid buffer, registered in_ready,
// synchronous flush and a saturating stall-cycle counter.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned PC_W        = DEF_PC_W,
  parameter int unsigned CTRL_W      = DEF_CTRL_W,
  parameter int unsigned STALL_CNT_W = DEF_STALL_CNT_W
) (
  input  logic         CLK,
  input  logic         RST,
  pipe_stage_skid_if.slave bus
);

  localparam int unsigned EntryW = DATA_W + PC_W + CTRL_W;

  state_e                 state_q, state_d;
  logic                   in_ready_q;
  logic [STALL_CNT_W-1:0] stall_cnt_q;

  logic              out_valid;
  logic              accept;
  logic              pop;
  logic              main_load;
  logic              main_from_skid;
  logic              skid_load;
  logic [EntryW-1:0] in_entry;
  logic [EntryW-1:0] main_d;
  logic [EntryW-1:0] main_q;
  logic [EntryW-1:0] skid_q;

  assign out_valid = (state_q != StEmpty);
  assign accept    = bus.in_valid & in_ready_q;
  assign pop       = out_valid & bus.out_ready;
  assign in_entry  = {bus.in_data, bus.in_pc, bus.in_ctrl};
  assign main_d    = main_from_skid ? skid_q : in_entry;

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          state_d   = StFull;
          main_load = 1'b1;
        end
      end
      StFull: begin
        if (accept && pop) begin
          main_load = 1'b1;
        end else if (accept) begin
          state_d   = StSkid;
          skid_load = 1'b1;
        end else if (pop) begin
          state_d = StEmpty;
        end
      end
      StSkid: begin
        // in_ready is low here, so no accept can coincide with the skid drain
        if (pop) begin
          state_d        = StFull;
          main_load      = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: state_d = StEmpty;
    endcase
    // Flush squashes held entries and drops any same-cycle accept; payloads keep their value
    if (bus.flush) begin
      state_d        = StEmpty;
      main_load      = 1'b0;
      main_from_skid = 1'b0;
      skid_load      = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StEmpty;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != StSkid);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt_q <= '0;
    end else if (out_valid && !bus.out_ready && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  pipe_entry_reg #(
    .WIDTH (EntryW)
  ) u_main_reg (
    .CLK    (CLK),
    .RST    (RST),
    .load_i (main_load),
    .d_i    (main_d),
    .q_o    (main_q)
  );

  pipe_entry_reg #(
    .WIDTH (EntryW)
  ) u_skid_reg (
    .CLK    (CLK),
    .RST    (RST),
    .load_i (skid_load),
    .d_i    (in_entry),
    .q_o    (skid_q)
  );

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = main_q[EntryW-1 -: DATA_W];
  assign bus.out_pc    = main_q[CTRL_W +: PC_W];
  assign bus.out_ctrl  = out_valid ? main_q[CTRL_W-1:0] : '0;
  assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench: a two-deep FIFO model predicts handshake, payload order and stall count.
module tb_pipe_stage_skid;

  localparam int unsigned DW = 32;
  localparam int unsigned PW = 32;
  localparam int unsigned CW = 12;
  localparam int unsigned SW = 4;
  localparam int unsigned StallMax = (1 << SW) - 1;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [PW-1:0] pc;
    logic [CW-1:0] ctrl;
  } entry_t;

  logic CLK;
  logic RST;

  pipe_stage_skid_if #(
    .DATA_W      (DW),
    .PC_W        (PW),
    .CTRL_W      (CW),
    .STALL_CNT_W (SW)
  ) bus ();

  pipe_stage_skid #(
    .DATA_W      (DW),
    .PC_W        (PW),
    .CTRL_W      (CW),
    .STALL_CNT_W (SW)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  entry_t      exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned stall_m  = 0;
  entry_t      last_head = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: compares every cycle against the model state at the start of the cycle
  always @(negedge CLK) begin
    entry_t e;
    if (RST) begin
      stall_m   = 0;
      last_head = '0;
    end else begin
      check("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_q.size() < 2});
      check("out_valid", {31'd0, bus.out_valid}, {31'd0, exp_q.size() != 0});
      check("stall_cnt", {28'd0, bus.stall_cnt}, stall_m);
      if (exp_q.size() != 0) begin
        e = exp_q[0];
        last_head = e;
        check("out_data", bus.out_data, e.data);
        check("out_pc", bus.out_pc, e.pc);
        check("out_ctrl", {20'd0, bus.out_ctrl}, {20'd0, e.ctrl});
        if (bus.out_ready) void'(exp_q.pop_front());
        else if (stall_m < StallMax) stall_m++;
      end else begin
        check("bubble_data", bus.out_data, last_head.data);
        check("bubble_pc", bus.out_pc, last_head.pc);
        check("bubble_ctrl", {20'd0, bus.out_ctrl}, 32'd0);
      end
    end
  end

  // One clock of stimulus; expected entries enter the scoreboard after the monitor's pop
  task automatic drive(input logic iv, input logic [31:0] d, input logic [31:0] pc,
                       input logic [11:0] c, input logic ordy, input logic fl,
                       input logic rst);
    logic rdy;
    @(posedge CLK);
    #1;
    RST           = rst;
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.in_pc     = pc;
    bus.in_ctrl   = c;
    bus.out_ready = ordy;
    bus.flush     = fl;
    rdy = (exp_q.size() < 2);
    #5;
    if (rst || fl) exp_q.delete();
    else if (iv && rdy) exp_q.push_back('{data: d, pc: pc, ctrl: c});
  endtask

  initial begin
    RST           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_pc     = '0;
    bus.in_ctrl   = '0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1, 0, 0);

    // Streaming at full rate
    drive(1, 32'h1000_0000, 32'h0, 12'h0A5, 1, 0, 0);
    drive(1, 32'h1000_0001, 32'h4, 12'h15A, 1, 0, 0);
    drive(1, 32'h1000_0002, 32'h8, 12'h2C3, 1, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0);

    // Backpressure fills the skid entry, then drains in order
    drive(1, 32'hAAAA_0010, 32'h10, 12'h101, 0, 0, 0);
    drive(1, 32'hAAAA_0014, 32'h14, 12'h102, 0, 0, 0);
    drive(1, 32'hAAAA_0018, 32'h18, 12'h103, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0);

    // Flush while in SKID with a concurrent offer that must be dropped
    drive(1, 32'hBBBB_0018, 32'h18, 12'h201, 0, 0, 0);
    drive(1, 32'hBBBB_001C, 32'h1C, 12'h202, 0, 0, 0);
    drive(1, 32'hBBBB_0020, 32'h20, 12'h203, 0, 1, 0);
    drive(0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0);

    // Bubble forces ctrl to zero while data holds
    drive(1, 32'hDEAD_BEEF, 32'h30, 12'hFFF, 1, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0);

    // Stall counter saturation, survives flush, cleared by reset
    drive(1, 32'hCCCC_0040, 32'h40, 12'h303, 0, 0, 0);
    repeat (20) drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 1);
    drive(0, 0, 0, 0, 1, 0, 0);

    // Reset wins over flush mid-SKID
    drive(1, 32'hDDDD_0050, 32'h50, 12'h404, 0, 0, 0);
    drive(1, 32'hDDDD_0054, 32'h54, 12'h405, 0, 0, 0);
    drive(1, 32'hDDDD_0058, 32'h58, 12'h406, 0, 1, 1);
    drive(0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0);

    // Randomised traffic with occasional flush and reset
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 9) < 7), $urandom, $urandom, 12'($urandom),
            ($urandom_range(0, 9) < ((i / 200) % 2 == 0 ? 6 : 2)),
            ($urandom_range(0, 31) == 0), ($urandom_range(0, 199) == 0));
    end

    repeat (4) drive(0, 0, 0, 0, 1, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
